// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared processor definitions: opcodes, pipeline-control states, stage-valid
// indices and the instruction decode helpers. The hazard controller and the
// EX-stage controller both import this package.
package pipe_hazard_ctrl_pkg;

    // Opcodes held in ir[3:0]. Codes that are not listed here (for example
    // nop = 10) neither read nor write a register and never branch.
    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STOP  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_BZ    = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_NAND  = 4'd8;
    localparam logic [3:0] OP_BNZ   = 4'd9;
    localparam logic [3:0] OP_BPZ   = 4'd13;

    // shift and ori are matched on the low three bits only. ir[3] is part of
    // their immediate field.
    localparam logic [2:0] OP3_SHIFT = 3'd3;
    localparam logic [2:0] OP3_ORI   = 3'd7;

    // ori always reads and writes r1, whatever is in ir[7:6].
    localparam logic [1:0] ORI_REG = 2'd1;

    // Indices into the stage-valid vector.
    localparam int V_RF        = 0;
    localparam int V_EX        = 1;
    localparam int V_WB        = 2;
    localparam int NUM_STAGE_V = 3;

    typedef enum logic [2:0] {
        ST_RESET_FILL,
        ST_RUN,
        ST_STALL,
        ST_FLUSH,
        ST_HALT
    } pipe_state_e;

    // Reader-side view of an instruction, used for the one sitting in RF.
    typedef struct packed {
        logic       rd_src1;
        logic       rd_src2;
        logic [1:0] src1;
        logic [1:0] src2;
    } rd_dec_t;

    // Writer/control-side view of an instruction, used for the one in EX.
    typedef struct packed {
        logic       is_load;
        logic       is_stop;
        logic       alu_wr;
        logic       is_bz;
        logic       is_bnz;
        logic       is_bpz;
        logic [1:0] dest;
    } wr_dec_t;

    function automatic logic is_shift(input logic [3:0] op);
        return op[2:0] == OP3_SHIFT;
    endfunction

    function automatic logic is_ori(input logic [3:0] op);
        return op[2:0] == OP3_ORI;
    endfunction

    // Two-operand ALU ops of the form rA = rA op rB.
    function automatic logic is_alu2(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND);
    endfunction

    function automatic rd_dec_t decode_rd(input logic [7:0] ir);
        rd_dec_t d;
        d         = '0;
        // store reads src1 for its data and src2 for its address.
        d.rd_src1 = is_alu2(ir[3:0]) || (ir[3:0] == OP_STORE) ||
                    is_shift(ir[3:0]) || is_ori(ir[3:0]);
        // load reads only its address register. ir[7:6] is its destination.
        d.rd_src2 = is_alu2(ir[3:0]) || (ir[3:0] == OP_LOAD) ||
                    (ir[3:0] == OP_STORE);
        d.src1    = is_ori(ir[3:0]) ? ORI_REG : ir[7:6];
        d.src2    = ir[5:4];
        return d;
    endfunction

    function automatic wr_dec_t decode_wr(input logic [7:0] ir);
        wr_dec_t d;
        d         = '0;
        d.is_load = (ir[3:0] == OP_LOAD);
        d.is_stop = (ir[3:0] == OP_STOP);
        d.alu_wr  = is_alu2(ir[3:0]) || is_shift(ir[3:0]) || is_ori(ir[3:0]);
        d.is_bz   = (ir[3:0] == OP_BZ);
        d.is_bnz  = (ir[3:0] == OP_BNZ);
        d.is_bpz  = (ir[3:0] == OP_BPZ);
        // ALU writers target src1. load targets ir[7:6], which is the same field.
        d.dest    = is_ori(ir[3:0]) ? ORI_REG : ir[7:6];
        return d;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational hazard detection between the RF-stage and EX-stage
// instructions: forwarding matches, load-use, branch resolution and stop.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [7:0] ir2,
    input  logic [7:0] ir3,
    input  logic       v2,
    input  logic       v3,
    input  logic       flag_z,
    input  logic       flag_n,
    output logic       byp1_hit,
    output logic       byp2_hit,
    output logic       load_use,
    output logic       br_taken,
    output logic       stop_ex
);

    rd_dec_t rd2;
    wr_dec_t wr3;
    logic    src1_match;
    logic    src2_match;

    // Decode both stages and compare ir2's sources with ir3's destination.
    always_comb begin
        rd2        = decode_rd(ir2);
        wr3        = decode_wr(ir3);
        src1_match = rd2.rd_src1 && (rd2.src1 == wr3.dest);
        src2_match = rd2.rd_src2 && (rd2.src2 == wr3.dest);

        // ALUout forwarding only applies when a valid ALU writer is in EX.
        // Bubbles and loads never forward.
        byp1_hit = v3 && wr3.alu_wr && src1_match;
        byp2_hit = v3 && wr3.alu_wr && src2_match;

        load_use = v2 && v3 && wr3.is_load && (src1_match || src2_match);

        br_taken = v3 && ((wr3.is_bz  &&  flag_z) ||
                          (wr3.is_bnz && !flag_z) ||
                          (wr3.is_bpz && !flag_n));

        stop_ex  = v3 && wr3.is_stop;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: sequences fill, stall, flush and halt for a
// fetch/RF/EX/WB pipeline. It also drives the per-stage enables, the IR load
// strobes and the registered ALUout forwarding selects.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] ir2,
    input  logic [7:0] ir3,
    input  logic       flag_z,
    input  logic       flag_n,
    output logic       en_fetch,
    output logic       en_rf,
    output logic       en_exec,
    output logic       en_wb,
    output logic       ld_ir2,
    output logic       ld_ir3,
    output logic       bypass_ALU1,
    output logic       bypass_ALU2,
    output logic       pc_sel_branch,
    output logic       stall,
    output logic       flush,
    output logic       halted
);

    pipe_state_e            state_q, state_d;
    logic [NUM_STAGE_V-1:0] vld_q, vld_d;
    // Set for the single drain cycle between stop leaving EX and HALT.
    logic                   halt_pend_q, halt_pend_d;
    logic                   byp1_q, byp1_d;
    logic                   byp2_q, byp2_d;

    logic fetch_c, ld2_c, ld3_c, stall_c, flush_c;
    logic byp1_hit, byp2_hit, load_use, br_taken, stop_ex;

    hazard_detect u_hazard_detect (
        .ir2      (ir2),
        .ir3      (ir3),
        .v2       (vld_q[V_RF]),
        .v3       (vld_q[V_EX]),
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .byp1_hit (byp1_hit),
        .byp2_hit (byp2_hit),
        .load_use (load_use),
        .br_taken (br_taken),
        .stop_ex  (stop_ex)
    );

    // Next state, valid-bit shifting and per-cycle control strobes.
    // Priority: stop > taken branch > load-use stall. A stall is ignored in
    // the same cycle as a flush because the ir2 that caused it is discarded.
    always_comb begin
        state_d     = state_q;
        vld_d       = vld_q;
        halt_pend_d = halt_pend_q;
        fetch_c     = 1'b0;
        ld2_c       = 1'b0;
        ld3_c       = 1'b0;
        stall_c     = 1'b0;
        flush_c     = 1'b0;

        if (state_q == ST_HALT) begin
            vld_d = '0;
        end else if (halt_pend_q) begin
            // The stop finishes WB this cycle. Nothing new enters the pipeline.
            vld_d       = '0;
            halt_pend_d = 1'b0;
            state_d     = ST_HALT;
        end else begin
            fetch_c     = 1'b1;
            ld2_c       = 1'b1;
            ld3_c       = 1'b1;
            vld_d[V_RF] = 1'b1;
            vld_d[V_EX] = vld_q[V_RF];
            vld_d[V_WB] = vld_q[V_EX];

            if (stop_ex) begin
                fetch_c     = 1'b0;
                ld2_c       = 1'b0;
                ld3_c       = 1'b0;
                vld_d[V_RF] = 1'b0;
                vld_d[V_EX] = 1'b0;
                halt_pend_d = 1'b1;
                state_d     = ST_RUN;
            end else if (br_taken) begin
                // The wrong-path instructions now entering RF and EX become
                // bubbles. Fetch continues from the target.
                flush_c     = 1'b1;
                vld_d[V_RF] = 1'b0;
                vld_d[V_EX] = 1'b0;
                state_d     = ST_FLUSH;
            end else if (load_use) begin
                // Hold IR2/IR3 and the PC. One bubble is inserted into EX.
                stall_c     = 1'b1;
                fetch_c     = 1'b0;
                ld2_c       = 1'b0;
                ld3_c       = 1'b0;
                vld_d[V_RF] = vld_q[V_RF];
                vld_d[V_EX] = 1'b0;
                state_d     = ST_STALL;
            end else if ((state_q == ST_RESET_FILL) && !vld_q[V_RF]) begin
                state_d = ST_RESET_FILL;
            end else begin
                state_d = ST_RUN;
            end
        end

        // Forward only when ir2 actually advances into EX on this edge.
        byp1_d = ld3_c && byp1_hit;
        byp2_d = ld3_c && byp2_hit;
    end

    // State, valid bits and forwarding selects. Reset clears every bubble,
    // pending halt and bypass immediately.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_RESET_FILL;
            vld_q       <= '0;
            halt_pend_q <= 1'b0;
            byp1_q      <= 1'b0;
            byp2_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            halt_pend_q <= halt_pend_d;
            byp1_q      <= byp1_d;
            byp2_q      <= byp2_d;
        end
    end

    // Fetch and IR loads are suppressed while resetn is low, so every
    // output is 0 during reset.
    always_comb begin
        en_fetch      = fetch_c && resetn;
        ld_ir2        = ld2_c && resetn;
        ld_ir3        = ld3_c && resetn;
        en_rf         = vld_q[V_RF];
        en_exec       = vld_q[V_EX];
        en_wb         = vld_q[V_WB];
        bypass_ALU1   = byp1_q;
        bypass_ALU2   = byp2_q;
        pc_sel_branch = flush_c;
        flush         = flush_c;
        stall         = stall_c;
        halted        = (state_q == ST_HALT);
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a table of single-cycle hazard
// vectors plus hand-written multi-cycle sequences.
module tb_pipe_hazard_ctrl;

    localparam logic [7:0] NOP = 8'h0A;

    // now = {stall, flush, pc_sel_branch, en_fetch, ld_ir2, ld_ir3}
    localparam logic [5:0] N_OK    = 6'b000111;
    localparam logic [5:0] N_STALL = 6'b100000;
    localparam logic [5:0] N_FLUSH = 6'b011111;
    localparam logic [5:0] N_STOP  = 6'b000000;
    // nxt = {en_rf, en_exec, en_wb, bypass_ALU1, bypass_ALU2, halted}
    localparam logic [5:0] X_B00   = 6'b111000;
    localparam logic [5:0] X_B10   = 6'b111100;
    localparam logic [5:0] X_B01   = 6'b111010;
    localparam logic [5:0] X_B11   = 6'b111110;
    localparam logic [5:0] X_STALL = 6'b101000;
    localparam logic [5:0] X_BUB2  = 6'b001000;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] ir2, ir3;
    logic       flag_z, flag_n;
    logic       en_fetch, en_rf, en_exec, en_wb, ld_ir2, ld_ir3;
    logic       bypass_ALU1, bypass_ALU2, pc_sel_branch, stall, flush, halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] ir2;
        logic [7:0] ir3;
        logic       fz;
        logic       fn;
        logic [5:0] now;
        logic [5:0] nxt;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] sb[$];

    always #5 clock = ~clock;

    pipe_hazard_ctrl dut (
        .clock         (clock),
        .resetn        (resetn),
        .ir2           (ir2),
        .ir3           (ir3),
        .flag_z        (flag_z),
        .flag_n        (flag_n),
        .en_fetch      (en_fetch),
        .en_rf         (en_rf),
        .en_exec       (en_exec),
        .en_wb         (en_wb),
        .ld_ir2        (ld_ir2),
        .ld_ir3        (ld_ir3),
        .bypass_ALU1   (bypass_ALU1),
        .bypass_ALU2   (bypass_ALU2),
        .pc_sel_branch (pc_sel_branch),
        .stall         (stall),
        .flush         (flush),
        .halted        (halted)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] now_o();
        return {stall, flush, pc_sel_branch, en_fetch, ld_ir2, ld_ir3};
    endfunction

    function automatic logic [5:0] nxt_o();
        return {en_rf, en_exec, en_wb, bypass_ALU1, bypass_ALU2, halted};
    endfunction

    function automatic logic [11:0] all_o();
        return {en_fetch, en_rf, en_exec, en_wb, ld_ir2, ld_ir3,
                bypass_ALU1, bypass_ALU2, pc_sel_branch, stall, flush, halted};
    endfunction

    function automatic vec_t mk(input logic [7:0] a2, input logic [7:0] a3,
                                input logic z, input logic n,
                                input logic [5:0] nw, input logic [5:0] nx);
        vec_t v;
        v.ir2 = a2; v.ir3 = a3; v.fz = z; v.fn = n; v.now = nw; v.nxt = nx;
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset, release on a falling edge, then advance n cycles (3 -> v2=v3=v4=1).
    task automatic reset_to(input int n);
        ir2 = NOP; ir3 = NOP; flag_z = 1'b0; flag_n = 1'b0;
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        #1;
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ir2, ir3 encodings: {src1, src2, op}
        vecs.push_back(mk(8'h94, 8'h64, 0, 0, N_OK, X_B01));    // add r1,r2 ; add r2,r1
        vecs.push_back(mk(8'h74, 8'h64, 0, 0, N_OK, X_B10));
        vecs.push_back(mk(8'h54, 8'h64, 0, 0, N_OK, X_B11));
        vecs.push_back(mk(8'hB4, 8'h64, 0, 0, N_OK, X_B00));
        vecs.push_back(mk(8'h94, 8'hB8, 0, 0, N_OK, X_B10));    // nand writes r2
        vecs.push_back(mk(8'h94, 8'h8B, 0, 0, N_OK, X_B10));    // shift, op 1011
        vecs.push_back(mk(8'h64, 8'h83, 0, 0, N_OK, X_B01));    // shift, op 0011
        vecs.push_back(mk(8'h94, 8'h07, 0, 0, N_OK, X_B01));    // ori writes r1
        vecs.push_back(mk(8'h94, 8'h0F, 0, 0, N_OK, X_B01));    // ori, op 1111
        vecs.push_back(mk(8'h30, 8'hD6, 0, 0, N_OK, X_B01));    // load addr from sub dest
        vecs.push_back(mk(8'hC0, 8'hD6, 0, 0, N_OK, X_B00));    // load dest != read
        vecs.push_back(mk(8'h94, 8'h62, 0, 0, N_OK, X_B00));    // store is no writer
        vecs.push_back(mk(8'hD6, 8'h60, 0, 0, N_STALL, X_STALL)); // load r1 ; sub r3,r1
        vecs.push_back(mk(8'h43, 8'h60, 0, 0, N_STALL, X_STALL)); // shift r1
        vecs.push_back(mk(8'h07, 8'h60, 0, 0, N_STALL, X_STALL)); // ori reads r1
        vecs.push_back(mk(8'hB4, 8'h60, 0, 0, N_OK, X_B00));    // no use, load not forwarded
        vecs.push_back(mk(8'h93, 8'h60, 0, 0, N_OK, X_B00));    // shift ignores src2
        vecs.push_back(mk(8'h94, 8'h05, 1, 0, N_FLUSH, X_BUB2)); // bz taken
        vecs.push_back(mk(8'h94, 8'h05, 0, 0, N_OK, X_B00));
        vecs.push_back(mk(8'h94, 8'h09, 1, 0, N_OK, X_B00));    // bnz not taken
        vecs.push_back(mk(8'h94, 8'h09, 0, 0, N_FLUSH, X_BUB2));
        vecs.push_back(mk(8'h94, 8'h0D, 0, 0, N_FLUSH, X_BUB2)); // bpz taken
        vecs.push_back(mk(8'h94, 8'h0D, 1, 1, N_OK, X_B00));
        vecs.push_back(mk(8'h94, NOP,   1, 0, N_OK, X_B00));    // nop never taken
        vecs.push_back(mk(8'h94, 8'h01, 0, 0, N_STOP, X_BUB2)); // stop in EX

        // Reset state and fill sequence
        ir2 = NOP; ir3 = NOP; flag_z = 1'b0; flag_n = 1'b0; resetn = 1'b0;
        #12;
        chk("reset_outputs", 16'(all_o()), 16'd0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        chk("fill_c0", 16'({en_fetch, en_rf, en_exec, en_wb}), 16'(4'b1000));
        tick();
        chk("fill_c1", 16'({en_fetch, en_rf, en_exec, en_wb}), 16'(4'b1100));
        tick();
        chk("fill_c2", 16'({en_fetch, en_rf, en_exec, en_wb}), 16'(4'b1110));
        tick();
        chk("fill_c3", 16'({en_fetch, en_rf, en_exec, en_wb}), 16'(4'b1111));

        // Table vectors: next-cycle expectations go through the scoreboard
        foreach (vecs[i]) begin
            logic [5:0] exp_nxt;
            reset_to(3);
            ir2 = vecs[i].ir2; ir3 = vecs[i].ir3;
            flag_z = vecs[i].fz; flag_n = vecs[i].fn;
            #2;
            chk($sformatf("vec%0d_now", i), 16'(now_o()), 16'(vecs[i].now));
            sb.push_back(vecs[i].nxt);
            tick();
            #2;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL vec%0d_sb: got empty scoreboard expected one entry", i);
            end else begin
                exp_nxt = sb.pop_front();
                chk($sformatf("vec%0d_nxt", i), 16'(nxt_o()), 16'(exp_nxt));
            end
        end

        // Load-use: one stall cycle, one bubble, then sub executes without forwarding
        reset_to(3);
        ir3 = 8'h60; ir2 = 8'hD6;
        #2;
        chk("lu_stall", 16'({stall, en_fetch, ld_ir2, ld_ir3}), 16'(4'b1000));
        tick(); #2;
        chk("lu_bubble", 16'({stall, en_fetch, en_exec, en_rf}), 16'(4'b0101));
        tick();
        ir3 = 8'hD6; ir2 = NOP;
        #2;
        chk("lu_exec", 16'({en_exec, bypass_ALU1, bypass_ALU2, stall}), 16'(4'b1000));

        // Taken bz: one flush cycle, two EX bubbles, a stale load-use is ignored
        reset_to(3);
        ir3 = 8'h35; ir2 = 8'h94; flag_z = 1'b1;
        #2;
        chk("br_taken", 16'({pc_sel_branch, flush, en_fetch, stall}), 16'(4'b1110));
        tick();
        ir3 = 8'h60; ir2 = 8'hD6;
        #2;
        chk("br_bubble1", 16'({pc_sel_branch, flush, stall, en_exec, en_rf}), 16'(5'b00000));
        tick();
        ir3 = 8'hD6; ir2 = 8'h94;
        #2;
        chk("br_bubble2", 16'({flush, stall, en_exec, en_rf}), 16'(4'b0001));
        tick();
        ir3 = 8'h94; ir2 = NOP;
        #2;
        chk("br_resume", 16'({en_exec, flush}), 16'(2'b10));

        // Stop with add behind it: drain one cycle, then HALT until reset
        reset_to(3);
        ir3 = 8'h01; ir2 = 8'h94;
        #2;
        chk("stop_now", 16'({en_fetch, ld_ir2, ld_ir3, halted, flush}), 16'd0);
        tick();
        ir3 = 8'h94; ir2 = 8'h94;
        #2;
        chk("stop_drain", 16'({en_fetch, en_rf, en_exec, en_wb, halted}), 16'(5'b00010));
        tick(); #2;
        chk("halt_enter", 16'({en_fetch, en_rf, en_exec, en_wb, ld_ir2, ld_ir3, halted}),
            16'(7'b0000001));
        ir3 = 8'h05; flag_z = 1'b1;
        repeat (5) tick();
        #2;
        chk("halt_hold", 16'({halted, flush, en_fetch, en_exec}), 16'(4'b1000));
        resetn = 1'b0;
        #1;
        chk("halt_reset", 16'(all_o()), 16'd0);

        // Reset pulsed during STALL: outputs drop at once, en_exec returns 2 cycles later
        reset_to(3);
        ir3 = 8'h60; ir2 = 8'hD6;
        tick(); #2;
        chk("stall_state", 16'({stall, en_exec, en_fetch}), 16'(3'b001));
        resetn = 1'b0;
        #1;
        chk("stall_reset", 16'(all_o()), 16'd0);
        ir3 = NOP; ir2 = NOP;
        @(negedge clock);
        resetn = 1'b1;
        #1;
        chk("rel_c0", 16'({en_exec, en_fetch, stall}), 16'(3'b010));
        tick();
        chk("rel_c1", 16'({en_exec, en_rf}), 16'(2'b01));
        tick();
        chk("rel_c2", 16'({en_exec, en_rf}), 16'(2'b11));

        // Reset clears a live bypass immediately
        reset_to(3);
        ir3 = 8'h64; ir2 = 8'h94;
        tick(); #2;
        chk("byp_pre", 16'({bypass_ALU1, bypass_ALU2}), 16'(2'b01));
        resetn = 1'b0;
        #1;
        chk("byp_reset", 16'({bypass_ALU1, bypass_ALU2}), 16'd0);
        #5;
        resetn = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
